// File: rtl/morse_symbol_sequencer.sv
// Button front-end for the Morse producer: one valid/ready symbol per press, timed dot/dash tones and gaps.
// Optional MORSE_AUTO_SPACE_EN: a full letter is closed with an automatic space after its last gap.
module morse_symbol_sequencer #(
  parameter int UNIT_CYCLES      = 10,
  parameter int MAX_SYMBOLS      = 5,
  parameter int DASH_UNITS       = 3,
  parameter int LETTER_GAP_UNITS = 3
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Dot,
  input  logic       Dash,
  input  logic       Space,
  input  logic       EndSeq,
  input  logic       Clear,
  output logic [2:0] sym_code,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       clr_pulse,
  output logic       dot_buzzer,
  output logic       dash_buzzer,
  output logic [2:0] sym_count,
  output logic       letter_full,
  output logic       busy,
  output logic       seq_done
);

  localparam logic [2:0] CODE_NONE  = 3'b000;
  localparam logic [2:0] CODE_DOT   = 3'b001;
  localparam logic [2:0] CODE_DASH  = 3'b010;
  localparam logic [2:0] CODE_SPACE = 3'b011;
  localparam logic [2:0] CODE_END   = 3'b100;

  localparam int MAX_UNITS = (DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS;
  localparam int UNIT_W    = $clog2(MAX_UNITS + 1);
  localparam int PRE_W     = $clog2(UNIT_CYCLES);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(UNIT_CYCLES - 1);
  localparam logic [UNIT_W-1:0] DASH_LAST = UNIT_W'(DASH_UNITS - 1);
  localparam logic [UNIT_W-1:0] LGAP_LAST = UNIT_W'(LETTER_GAP_UNITS - 1);

  typedef enum logic [2:0] {IDLE, OFFER, TONE, GAP, LGAP, DONE} state_t;

  state_t            state;
  logic [PRE_W-1:0]  pre;
  logic [UNIT_W-1:0] ucnt;
  logic              prev_dot, prev_dash, prev_space, prev_end, prev_clear;
  logic              dot_edge, dash_edge, space_edge, end_edge, clear_edge;
  logic              pick_valid;
  logic [2:0]        pick_code;
  logic              pre_last;
  logic [UNIT_W-1:0] tone_last;

  assign dot_edge    = Dot & ~prev_dot;
  assign dash_edge   = Dash & ~prev_dash;
  assign space_edge  = Space & ~prev_space;
  assign end_edge    = EndSeq & ~prev_end;
  assign clear_edge  = Clear & ~prev_clear;
  assign pre_last    = (pre == PRE_LAST);
  assign tone_last   = dash_buzzer ? DASH_LAST : '0;
  assign letter_full = (sym_count == 3'(MAX_SYMBOLS));
  assign busy        = (state != IDLE);

  // Only the highest-priority edge survives; a dot/dash into a full letter is dropped entirely.
  always_comb begin
    pick_valid = 1'b0;
    pick_code  = CODE_NONE;
    if (end_edge) begin
      pick_valid = 1'b1;
      pick_code  = CODE_END;
    end else if (space_edge) begin
      pick_valid = 1'b1;
      pick_code  = CODE_SPACE;
    end else if (dash_edge) begin
      pick_valid = ~letter_full;
      pick_code  = CODE_DASH;
    end else if (dot_edge) begin
      pick_valid = ~letter_full;
      pick_code  = CODE_DOT;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      pre         <= '0;
      ucnt        <= '0;
      prev_dot    <= 1'b1;
      prev_dash   <= 1'b1;
      prev_space  <= 1'b1;
      prev_end    <= 1'b1;
      prev_clear  <= 1'b1;
      sym_code    <= CODE_NONE;
      sym_valid   <= 1'b0;
      clr_pulse   <= 1'b0;
      dot_buzzer  <= 1'b0;
      dash_buzzer <= 1'b0;
      sym_count   <= 3'd0;
      seq_done    <= 1'b0;
    end else begin
      prev_dot   <= Dot;
      prev_dash  <= Dash;
      prev_space <= Space;
      prev_end   <= EndSeq;
      prev_clear <= Clear;
      clr_pulse  <= 1'b0;
      pre        <= pre_last ? '0 : pre + 1'b1;
      if (pre_last) ucnt <= ucnt + 1'b1;

      if (clear_edge) begin
        // Clear wins even over a handshake completing this cycle.
        state       <= IDLE;
        pre         <= '0;
        ucnt        <= '0;
        sym_code    <= CODE_NONE;
        sym_valid   <= 1'b0;
        dot_buzzer  <= 1'b0;
        dash_buzzer <= 1'b0;
        sym_count   <= 3'd0;
        seq_done    <= 1'b0;
        clr_pulse   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (pick_valid) begin
              state     <= OFFER;
              pre       <= '0;
              ucnt      <= '0;
              sym_code  <= pick_code;
              sym_valid <= 1'b1;
            end
          end
          OFFER: begin
            if (sym_ready) begin
              pre       <= '0;
              ucnt      <= '0;
              sym_valid <= 1'b0;
              sym_code  <= CODE_NONE;
              case (sym_code)
                CODE_DOT, CODE_DASH: begin
                  state       <= TONE;
                  dot_buzzer  <= (sym_code == CODE_DOT);
                  dash_buzzer <= (sym_code == CODE_DASH);
                  if (!letter_full) sym_count <= sym_count + 3'd1;
                end
                CODE_SPACE: begin
                  state     <= LGAP;
                  sym_count <= 3'd0;
                end
                default: begin
                  state    <= DONE;
                  seq_done <= 1'b1;
                end
              endcase
            end
          end
          TONE: begin
            if (pre_last && ucnt == tone_last) begin
              state       <= GAP;
              pre         <= '0;
              ucnt        <= '0;
              dot_buzzer  <= 1'b0;
              dash_buzzer <= 1'b0;
            end
          end
          GAP: begin
            if (pre_last && ucnt == '0) begin
              pre  <= '0;
              ucnt <= '0;
`ifdef MORSE_AUTO_SPACE_EN
              if (letter_full) begin
                state     <= OFFER;
                sym_code  <= CODE_SPACE;
                sym_valid <= 1'b1;
              end else begin
                state <= IDLE;
              end
`else
              state <= IDLE;
`endif
            end
          end
          LGAP: begin
            if (pre_last && ucnt == LGAP_LAST) begin
              state <= IDLE;
              pre   <= '0;
              ucnt  <= '0;
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed-plus-random bench for morse_symbol_sequencer against a transaction-level model of letters and timing.
module tb_morse_symbol_sequencer;

  localparam int U     = 10;
  localparam int MAXS  = 5;
  localparam int DASHU = 3;
  localparam int LGAPU = 3;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Dot = 1'b0, Dash = 1'b0, Space = 1'b0, EndSeq = 1'b0, Clear = 1'b0;
  logic       sym_ready = 1'b0;
  logic [2:0] sym_code;
  logic       sym_valid, clr_pulse, dot_buzzer, dash_buzzer, letter_full, busy, seq_done;
  logic [2:0] sym_count;

  int checks = 0;
  int failures = 0;
  int model_count = 0;
  bit model_done = 1'b0;

  always #5 clk = ~clk;

  morse_symbol_sequencer #(
    .UNIT_CYCLES(U), .MAX_SYMBOLS(MAXS), .DASH_UNITS(DASHU), .LETTER_GAP_UNITS(LGAPU)
  ) dut (
    .clk(clk), .Reset(Reset), .Dot(Dot), .Dash(Dash), .Space(Space), .EndSeq(EndSeq),
    .Clear(Clear), .sym_code(sym_code), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .clr_pulse(clr_pulse), .dot_buzzer(dot_buzzer), .dash_buzzer(dash_buzzer),
    .sym_count(sym_count), .letter_full(letter_full), .busy(busy), .seq_done(seq_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected symbol for a set of simultaneous presses {end,space,dash,dot}; 0 = nothing issued.
  function automatic logic [2:0] model_pick(input logic [3:0] m);
    if (model_done) return 3'd0;
    if (m[3]) return 3'd4;
    if (m[2]) return 3'd3;
    if (m[1]) return (model_count == MAXS) ? 3'd0 : 3'd2;
    if (m[0]) return (model_count == MAXS) ? 3'd0 : 3'd1;
    return 3'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    {EndSeq, Space, Dash, Dot} = m;
    step();
    {EndSeq, Space, Dash, Dot} = 4'b0000;
  endtask

  task automatic offer_xfer(input logic [2:0] code, input int delay);
    int bad = 0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (sym_valid !== 1'b1 || sym_code !== code) bad++;
      step();
    end
    check("offer_hold", 32'(bad), 0);
    sym_ready = 1'b1;
    @(negedge clk);
    check("offer_valid", 32'(sym_valid), 1);
    check("offer_code", 32'(sym_code), 32'(code));
    step();
    sym_ready = 1'b0;
    if (code == 3'd1 || code == 3'd2) model_count = (model_count < MAXS) ? model_count + 1 : MAXS;
    else if (code == 3'd3) model_count = 0;
    else model_done = 1'b1;
  endtask

  task automatic run_lgap();
    int bad = 0;
    for (int i = 0; i < LGAPU * U; i++) begin
      @(negedge clk);
      if (i == 0) check("count_cleared", 32'(sym_count), 0);
      if (dot_buzzer !== 1'b0 || dash_buzzer !== 1'b0 || sym_valid !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    check("lgap", 32'(bad), 0);
    @(negedge clk);
    check("idle_after_lgap", 32'(busy), 0);
    step();
  endtask

  task automatic run_tone(input logic [2:0] code);
    int bad = 0;
    int len = (code == 3'd2) ? DASHU * U : U;
    bit auto_sp = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) check("count_after", 32'(sym_count), 32'(model_count));
      if (dot_buzzer !== (code == 3'd1) || dash_buzzer !== (code == 3'd2) ||
          sym_valid !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    check("tone", 32'(bad), 0);
    bad = 0;
    for (int i = 0; i < U; i++) begin
      @(negedge clk);
      if (dot_buzzer !== 1'b0 || dash_buzzer !== 1'b0 || sym_valid !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    check("gap", 32'(bad), 0);
`ifdef MORSE_AUTO_SPACE_EN
    auto_sp = (model_count == MAXS);
`endif
    if (auto_sp) begin
      offer_xfer(3'd3, int'($urandom_range(0, 3)));
      run_lgap();
    end else begin
      @(negedge clk);
      check("idle_after_gap", 32'(busy), 0);
      check("letter_full", 32'(letter_full), 32'(model_count == MAXS));
      step();
    end
  endtask

  task automatic run_done();
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (seq_done !== 1'b1 || busy !== 1'b1 || sym_valid !== 1'b0) bad++;
      step();
    end
    check("done_hold", 32'(bad), 0);
  endtask

  task automatic symbol(input logic [3:0] m, input int delay);
    logic [2:0] exp;
    int bad = 0;
    exp = model_pick(m);
    press(m);
    if (exp == 3'd0) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (sym_valid !== 1'b0 || busy !== model_done) bad++;
        step();
      end
      check("ignored", 32'(bad), 0);
    end else begin
      offer_xfer(exp, delay);
      if (exp == 3'd1 || exp == 3'd2) run_tone(exp);
      else if (exp == 3'd3) run_lgap();
      else run_done();
    end
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    model_count = 0;
    model_done = 1'b0;
    @(negedge clk);
    check("clr_pulse_hi", 32'(clr_pulse), 1);
    check("clr_state", 32'({busy, sym_valid, dot_buzzer, dash_buzzer, seq_done, sym_count}), 0);
    step();
    @(negedge clk);
    check("clr_pulse_lo", 32'(clr_pulse), 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [3:0] m;
    // Reset with Dot held and the producer ready.
    Dot = 1'b1;
    sym_ready = 1'b1;
    #12;
    check("reset_outputs", 32'({sym_code, sym_valid, clr_pulse, dot_buzzer, dash_buzzer,
                                sym_count, letter_full, busy, seq_done}), 0);
    @(negedge clk);
    Reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sym_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("held_dot_no_fire", 32'(bad), 0);
    step();
    Dot = 1'b0;
    sym_ready = 1'b0;
    step();
    symbol(4'b0001, 0);
    symbol(4'b0010, 7);
    // Simultaneous EndSeq and Dot, then presses while done.
    symbol(4'b1001, 1);
    symbol(4'b0001, 0);
    symbol(4'b0100, 0);
    do_clear();
    // Fill a letter, overflow it, then close it.
    for (int i = 0; i < 5; i++) symbol(4'b0001, int'($urandom_range(0, 2)));
    symbol(4'b0001, 0);
    symbol(4'b0100, 2);
    // Clear in the middle of a dash tone.
    press(4'b0010);
    offer_xfer(3'd2, 0);
    for (int i = 0; i < 12; i++) step();
    @(negedge clk);
    check("tone_before_clear", 32'(dash_buzzer), 1);
    step();
    do_clear();
    // Random press sequences checked against the model.
    for (int n = 0; n < 14; n++) begin
      if (model_done && $urandom_range(0, 1) == 1) begin
        do_clear();
      end else begin
        if ($urandom_range(0, 3) == 0) m = 4'($urandom_range(1, 15));
        else m = 4'(1 << $urandom_range(0, 3));
        symbol(m, int'($urandom_range(0, 5)));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
